// File: rtl/tnn_ternary_neuron_acc.sv
// -----------------------------------------------------------------------------
// tnn_ternary_neuron_acc
//
// Sequential ternary-neuron back end. Each beat carries the outputs of two
// popcount units (positive-weight and negative-weight inputs). Over NUM_CHUNKS
// accepted beats the block accumulates the saturated signed difference
// (pos - neg), then thresholds the final sum into a ternary activation and
// holds the result until the consumer takes it.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   acc_clear_i  synchronous abort: drops the partial sum and any held result
//   in_valid_i   a beat is offered
//   in_ready_o   a beat can be accepted (ACCUM state, not in reset)
//   pc_pos_i     unsigned popcount of positive-weight inputs
//   pc_neg_i     unsigned popcount of negative-weight inputs
//   out_valid_o  a result is held
//   out_ready_i  the consumer takes the held result
//   out_act_o    ternary activation: 01 = +1, 00 = 0, 11 = -1
//   out_sum_o    signed final sum
//
// State | meaning
// ------+------------------------------------------------------------
// ACCUM | accepting beats, summing into acc_q
// HOLD  | result registered on out_*, waiting for out_ready_i
// -----------------------------------------------------------------------------
module tnn_ternary_neuron_acc #(
  parameter int PC_WIDTH   = 5,
  parameter int NUM_CHUNKS = 4,
  parameter int ACC_WIDTH  = 8,
  parameter int THR_HI     = 5,
  parameter int THR_LO     = -5
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        acc_clear_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [PC_WIDTH-1:0]         pc_pos_i,
  input  logic [PC_WIDTH-1:0]         pc_neg_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [1:0]                  out_act_o,
  output logic signed [ACC_WIDTH-1:0] out_sum_o
);

  localparam int CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_CHUNKS - 1);

  localparam logic signed [ACC_WIDTH-1:0] THR_HI_C = ACC_WIDTH'(THR_HI);
  localparam logic signed [ACC_WIDTH-1:0] THR_LO_C = ACC_WIDTH'(THR_LO);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  localparam logic [1:0] ACT_POS  = 2'b01;
  localparam logic [1:0] ACT_ZERO = 2'b00;
  localparam logic [1:0] ACT_NEG  = 2'b11;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t                      state_q;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]            cnt_q;
  logic                        out_valid_q;
  logic [1:0]                  out_act_q;
  logic signed [ACC_WIDTH-1:0] out_sum_q;

  logic signed [ACC_WIDTH:0]   acc_ext;
  logic signed [ACC_WIDTH:0]   pos_ext;
  logic signed [ACC_WIDTH:0]   neg_ext;
  logic signed [ACC_WIDTH:0]   sum_wide;
  logic signed [ACC_WIDTH-1:0] sum_d;
  logic [1:0]                  act_d;

  // One extra bit of headroom; the two top bits disagree exactly when the
  // result does not fit in ACC_WIDTH bits, and the top bit gives the direction.
  always_comb begin
    acc_ext  = {acc_q[ACC_WIDTH-1], acc_q};
    pos_ext  = $signed((ACC_WIDTH+1)'(pc_pos_i));
    neg_ext  = $signed((ACC_WIDTH+1)'(pc_neg_i));
    sum_wide = acc_ext + pos_ext - neg_ext;
    if (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1]) begin
      sum_d = sum_wide[ACC_WIDTH] ? SAT_MIN : SAT_MAX;
    end else begin
      sum_d = sum_wide[ACC_WIDTH-1:0];
    end

    act_d = ACT_ZERO;
    if (sum_d >= THR_HI_C) begin
      act_d = ACT_POS;
    end else if (sum_d <= THR_LO_C) begin
      act_d = ACT_NEG;
    end
  end

  // Decoded from state and reset only, so it never depends on the handshakes.
  assign in_ready_o = (state_q == ST_ACCUM) && !rst_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_act_q   <= ACT_ZERO;
      out_sum_q   <= '0;
    end else if (acc_clear_i) begin
      // Abort wins over any beat or handshake; the last result stays visible
      // on out_act/out_sum but is no longer flagged valid.
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (in_valid_i) begin
            if (cnt_q == CNT_LAST) begin
              out_sum_q   <= sum_d;
              out_act_q   <= act_d;
              out_valid_q <= 1'b1;
              acc_q       <= '0;
              cnt_q       <= '0;
              state_q     <= ST_HOLD;
            end else begin
              acc_q <= sum_d;
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_ACCUM;
          end
        end
        default: begin
          state_q <= ST_ACCUM;
        end
      endcase
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_act_o   = out_act_q;
  assign out_sum_o   = out_sum_q;

endmodule
